// File: rtl/debounce_timer_arbiter.sv
// Shares one debounce down-counter among NUM_CH debouncer channels.
// Round-robin grant, configurable period, and abort when the owner withdraws its request.
module debounce_timer_arbiter #(
    parameter int               NUM_CH     = 4,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] RST_PERIOD = 16'd1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] timer_req,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_wr,
    output logic [NUM_CH-1:0] timer_grant,
    output logic [NUM_CH-1:0] timer_done,
    output logic              busy,
    output logic [CNT_W-1:0]  count_val
);

    localparam int                PTR_W    = $clog2(NUM_CH);
    localparam logic [PTR_W:0]    NUM_CH_W = (PTR_W+1)'(NUM_CH);
    localparam logic [PTR_W-1:0]  LAST_CH  = PTR_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_CH-1:0]   r_grant;
    logic [NUM_CH-1:0]   r_done;
    logic                r_busy;
    logic [PTR_W-1:0]    r_chan;
    logic [PTR_W-1:0]    r_rrPtr;

    logic [CNT_W-1:0]    w_countNext;
    logic [NUM_CH-1:0]   w_grantNext;
    logic [NUM_CH-1:0]   w_doneNext;
    logic [PTR_W-1:0]    w_chanNext;
    logic [PTR_W-1:0]    w_ptrNext;
    logic                w_found;
    logic [PTR_W-1:0]    w_pick;
    logic [PTR_W:0]      w_idx;
    logic                w_abort;
    logic                w_expire;

    // A written period of zero would never expire cleanly, so it is stored as one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_period <= RST_PERIOD;
        end else if (cfg_wr) begin
            r_period <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
        end
    end

    // Round-robin search from r_rrPtr; the wrap compares against NUM_CH so odd channel counts work.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rrPtr} + (PTR_W+1)'(i);
            if (w_idx >= NUM_CH_W) begin
                w_idx = w_idx - NUM_CH_W;
            end
            if (!w_found && timer_req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_abort  = ~timer_req[r_chan];
    assign w_expire = (r_count == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_chan  <= '0;
            r_rrPtr <= '0;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_grantNext;
            r_done  <= w_doneNext;
            r_busy  <= (w_nextState != IDLE);
            r_count <= w_countNext;
            r_chan  <= w_chanNext;
            r_rrPtr <= w_ptrNext;
        end
    end

    // Withdrawal of the owner's request wins over expiry in the same cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = COUNT;
                end
            end
            COUNT: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_expire) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_grantNext = r_grant;
        w_doneNext  = '0;
        w_countNext = r_count;
        w_chanNext  = r_chan;
        w_ptrNext   = r_rrPtr;
        case (r_state)
            IDLE: begin
                w_grantNext = '0;
                w_countNext = '0;
                if (w_found) begin
                    w_grantNext = ONE_HOT0 << w_pick;
                    w_countNext = r_period - CNT_W'(1);
                    w_chanNext  = w_pick;
                    w_ptrNext   = (w_pick == LAST_CH) ? '0 : w_pick + PTR_W'(1);
                end
            end
            COUNT: begin
                if (w_abort) begin
                    w_grantNext = '0;
                    w_countNext = '0;
                end else if (w_expire) begin
                    w_doneNext = ONE_HOT0 << r_chan;
                end else begin
                    w_countNext = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_grantNext = '0;
                w_countNext = '0;
            end
        endcase
    end

    assign timer_grant = r_grant;
    assign timer_done  = r_done;
    assign busy        = r_busy;
    assign count_val   = r_count;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Scoreboard bench for debounce_timer_arbiter: a 4-channel instance and a 3-channel instance
// share the clock, request bus and config inputs; each is held in reset while the other runs.
module tb_debounce_timer_arbiter;

    localparam int KGRANT = 0;
    localparam int KDONE  = 1;
    localparam int KDROP  = 2;

    typedef struct {
        int kind;
        int value;
        int gap;
    } expEvent_t;

    logic        CLK;
    logic        RST4;
    logic        RST3;
    logic [3:0]  req;
    logic [15:0] cfgPeriod;
    logic        cfgWr;

    logic [3:0]  grant4;
    logic [3:0]  done4;
    logic        busy4;
    logic [15:0] count4;
    logic [2:0]  grant3;
    logic [2:0]  done3;
    logic        busy3;
    logic [15:0] count3;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int lastCyc4 = 0;
    int lastCyc3 = 0;
    logic [3:0] prevGrant4 = '0;
    logic [2:0] prevGrant3 = '0;
    expEvent_t expQ4[$];
    expEvent_t expQ3[$];

    debounce_timer_arbiter #(.NUM_CH(4), .CNT_W(16), .RST_PERIOD(16'd1000)) dut4 (
        .CLK(CLK), .RST(RST4), .timer_req(req), .cfg_period(cfgPeriod), .cfg_wr(cfgWr),
        .timer_grant(grant4), .timer_done(done4), .busy(busy4), .count_val(count4)
    );

    debounce_timer_arbiter #(.NUM_CH(3), .CNT_W(16), .RST_PERIOD(16'd4)) dut3 (
        .CLK(CLK), .RST(RST3), .timer_req(req[2:0]), .cfg_period(cfgPeriod), .cfg_wr(cfgWr),
        .timer_grant(grant3), .timer_done(done3), .busy(busy3), .count_val(count3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle++;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    task automatic expectEvent(input int dut, input int kind, input int value, input int gap);
        expEvent_t e;
        e.kind  = kind;
        e.value = value;
        e.gap   = gap;
        if (dut == 4) expQ4.push_back(e);
        else          expQ3.push_back(e);
    endtask

    task automatic observe(input int dut, input int kind, input int value);
        expEvent_t e;
        int  last;
        bit  have;
        e    = '{0, 0, 0};
        have = 1'b0;
        if (dut == 4) begin
            if (expQ4.size() > 0) begin
                e    = expQ4.pop_front();
                have = 1'b1;
            end
            last     = lastCyc4;
            lastCyc4 = cycle;
        end else begin
            if (expQ3.size() > 0) begin
                e    = expQ3.pop_front();
                have = 1'b1;
            end
            last     = lastCyc3;
            lastCyc3 = cycle;
        end
        if (!have) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d event: got kind %0d value %0d, expected no event (cycle %0d)",
                     dut, kind, value, cycle);
        end else begin
            checkOutput($sformatf("dut%0d event kind", dut), kind, e.kind);
            checkOutput($sformatf("dut%0d event value", dut), value, e.value);
            if (e.gap >= 0) checkOutput($sformatf("dut%0d event spacing", dut), cycle - last, e.gap);
        end
    endtask

    always @(negedge CLK) begin
        if (RST4) begin
            prevGrant4 = '0;
        end else begin
            checkOutput("dut4 busy", int'(busy4), int'(|grant4));
            checkOutput("dut4 grant onehot", int'($onehot0(grant4)), 1);
            if (done4 != '0) observe(4, KDONE, int'(done4));
            if (grant4 != prevGrant4) observe(4, (grant4 == '0) ? KDROP : KGRANT, int'(grant4));
            prevGrant4 = grant4;
        end
    end

    always @(negedge CLK) begin
        if (RST3) begin
            prevGrant3 = '0;
        end else begin
            checkOutput("dut3 busy", int'(busy3), int'(|grant3));
            checkOutput("dut3 grant onehot", int'($onehot0(grant3)), 1);
            if (done3 != '0) observe(3, KDONE, int'(done3));
            if (grant3 != prevGrant3) observe(3, (grant3 == '0) ? KDROP : KGRANT, int'(grant3));
            prevGrant3 = grant3;
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic wr, input logic [15:0] period, input int n);
        req       = r;
        cfgWr     = wr;
        cfgPeriod = period;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            cfgWr = 1'b0;
        end
    endtask

    task automatic checkIdle4(input string tag);
        checkOutput({tag, " grant"}, int'(grant4), 0);
        checkOutput({tag, " done"},  int'(done4),  0);
        checkOutput({tag, " busy"},  int'(busy4),  0);
        checkOutput({tag, " count"}, int'(count4), 0);
    endtask

    initial begin
        RST4 = 1'b1;
        RST3 = 1'b1;
        req = '0;
        cfgPeriod = '0;
        cfgWr = 1'b0;
        applyStimulus(4'b0000, 1'b0, 16'd0, 3);
        checkIdle4("reset");

        $display("[TB] period 1000, single requester ch0");
        expectEvent(4, KGRANT, 1, -1);
        expectEvent(4, KDONE,  1, 1000);
        expectEvent(4, KDROP,  0, 1);
        RST4 = 1'b0;
        applyStimulus(4'b0001, 1'b0, 16'd0, 1);
        checkOutput("first grant count", int'(count4), 999);
        applyStimulus(4'b0001, 1'b0, 16'd0, 1000);
        applyStimulus(4'b0000, 1'b0, 16'd0, 3);

        $display("[TB] period 5, all four requesting");
        RST4 = 1'b1;
        applyStimulus(4'b0000, 1'b0, 16'd0, 2);
        RST4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expectEvent(4, KGRANT, 1 << (i % 4), (i == 0) ? -1 : 1);
            expectEvent(4, KDONE,  1 << (i % 4), 5);
            expectEvent(4, KDROP,  0, 1);
        end
        applyStimulus(4'b0000, 1'b1, 16'd5, 1);
        applyStimulus(4'b1111, 1'b0, 16'd5, 35);
        applyStimulus(4'b0000, 1'b0, 16'd5, 3);

        $display("[TB] period 10, ch2 withdraws, ch3 takes over");
        expectEvent(4, KGRANT, 4, -1);
        expectEvent(4, KDROP,  0, 4);
        expectEvent(4, KGRANT, 8, 1);
        expectEvent(4, KDONE,  8, 10);
        expectEvent(4, KDROP,  0, 1);
        applyStimulus(4'b0000, 1'b1, 16'd10, 1);
        applyStimulus(4'b0100, 1'b0, 16'd10, 4);
        checkOutput("count before abort", int'(count4), 6);
        applyStimulus(4'b1000, 1'b0, 16'd10, 13);
        applyStimulus(4'b0000, 1'b0, 16'd10, 2);

        $display("[TB] zero period write, then write 20 mid-count");
        expectEvent(4, KGRANT, 1, -1);
        expectEvent(4, KDONE,  1, 1);
        expectEvent(4, KDROP,  0, 1);
        expectEvent(4, KGRANT, 1, 1);
        expectEvent(4, KDONE,  1, 20);
        expectEvent(4, KDROP,  0, 1);
        applyStimulus(4'b0000, 1'b1, 16'd0, 1);
        applyStimulus(4'b0001, 1'b0, 16'd0, 1);
        checkOutput("period one count", int'(count4), 0);
        applyStimulus(4'b0001, 1'b1, 16'd20, 3);
        checkOutput("period twenty count", int'(count4), 19);
        applyStimulus(4'b0001, 1'b0, 16'd20, 20);
        applyStimulus(4'b0000, 1'b0, 16'd20, 3);

        $display("[TB] reset in the middle of a count");
        expectEvent(4, KGRANT, 2, -1);
        applyStimulus(4'b0010, 1'b0, 16'd20, 17);
        checkOutput("count before reset", int'(count4), 3);
        RST4 = 1'b1;
        applyStimulus(4'b0010, 1'b0, 16'd20, 1);
        checkIdle4("mid-count reset");
        RST4 = 1'b0;
        expectEvent(4, KGRANT, 4, -1);
        expectEvent(4, KDONE,  4, 3);
        expectEvent(4, KDROP,  0, 1);
        applyStimulus(4'b0000, 1'b1, 16'd3, 1);
        applyStimulus(4'b0100, 1'b0, 16'd3, 1);
        checkOutput("grant after reset", int'(grant4), 4);
        applyStimulus(4'b0100, 1'b0, 16'd3, 3);
        applyStimulus(4'b0000, 1'b0, 16'd3, 3);

        $display("[TB] three channels, ch0 and ch2 requesting");
        RST4 = 1'b1;
        expectEvent(3, KGRANT, 1, -1);
        expectEvent(3, KDONE,  1, 4);
        expectEvent(3, KDROP,  0, 1);
        expectEvent(3, KGRANT, 4, 1);
        expectEvent(3, KDONE,  4, 4);
        expectEvent(3, KDROP,  0, 1);
        expectEvent(3, KGRANT, 1, 1);
        expectEvent(3, KDONE,  1, 4);
        expectEvent(3, KDROP,  0, 1);
        applyStimulus(4'b0000, 1'b0, 16'd0, 1);
        RST3 = 1'b0;
        applyStimulus(4'b0101, 1'b0, 16'd0, 18);
        applyStimulus(4'b0000, 1'b0, 16'd0, 3);

        checkOutput("dut4 events still pending", expQ4.size(), 0);
        checkOutput("dut3 events still pending", expQ3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
